keyboard_voice_alloc: RTL

//  Parametrised successor to the fixed four-channel scan-code-to-tone decode. Parses a raw PS/2

---
 rtl/kva_pkg.sv | 88 ++++++++
 rtl/kva_scan_parser.sv | 71 +++++++
 rtl/keyboard_voice_alloc.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/kva_pkg.sv
// -----------------------------------------------------------------------------
// kva_pkg
// Shared definitions for the keyboard voice allocator:
//   - parse_state_t    : PS/2 byte-stream parser states
//   - SC_BREAK, SC_EXT : F0 break prefix and E0 extended prefix
//   - KVA_NUM_KEYS     : number of mapped keys (indices 0..19)
//   - key_idx()        : scan code -> {hit, key index}
//   - key_freq()       : key index -> tone frequency word
// -----------------------------------------------------------------------------
package kva_pkg;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_BREAK   = 2'd1,
        PS_EXT     = 2'd2,
        PS_EXT_BRK = 2'd3
    } parse_state_t;

    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam int         KVA_NUM_KEYS = 20;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } key_lookup_t;

    // Scan code to key index; hit=0 for any code outside the playable row.
    function automatic key_lookup_t key_idx(input logic [7:0] scan);
        key_lookup_t r;
        r.hit = 1'b1;
        r.idx = 5'd0;
        case (scan)
            8'h15: r.idx = 5'd0;
            8'h1C: r.idx = 5'd1;
            8'h1D: r.idx = 5'd2;
            8'h1B: r.idx = 5'd3;
            8'h24: r.idx = 5'd4;
            8'h23: r.idx = 5'd5;
            8'h2B: r.idx = 5'd6;
            8'h2C: r.idx = 5'd7;
            8'h34: r.idx = 5'd8;
            8'h35: r.idx = 5'd9;
            8'h33: r.idx = 5'd10;
            8'h3B: r.idx = 5'd11;
            8'h43: r.idx = 5'd12;
            8'h42: r.idx = 5'd13;
            8'h44: r.idx = 5'd14;
            8'h4B: r.idx = 5'd15;
            8'h4D: r.idx = 5'd16;
            8'h4C: r.idx = 5'd17;
            8'h52: r.idx = 5'd18;
            8'h5B: r.idx = 5'd19;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

    // Key index to frequency word for the tone generators.
    function automatic logic [15:0] key_freq(input logic [4:0] idx);
        logic [15:0] f;
        case (idx)
            5'd0:    f = 16'd400;
            5'd1:    f = 16'd423;
            5'd2:    f = 16'd448;
            5'd3:    f = 16'd475;
            5'd4:    f = 16'd503;
            5'd5:    f = 16'd533;
            5'd6:    f = 16'd565;
            5'd7:    f = 16'd599;
            5'd8:    f = 16'd634;
            5'd9:    f = 16'd672;
            5'd10:   f = 16'd712;
            5'd11:   f = 16'd755;
            5'd12:   f = 16'd800;
            5'd13:   f = 16'd847;
            5'd14:   f = 16'd897;
            5'd15:   f = 16'd951;
            5'd16:   f = 16'd1007;
            5'd17:   f = 16'd1067;
            5'd18:   f = 16'd1131;
            5'd19:   f = 16'd1198;
            default: f = 16'd1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/kva_scan_parser.sv
// -----------------------------------------------------------------------------
// kva_scan_parser
// PS/2 scan-code byte parser. Tracks F0 (break) and E0 (extended) prefixes and
// emits a make or release strobe for mapped keys. Extended keys are consumed
// and ignored.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   scan_valid  : one-cycle strobe qualifying scan_code
//   scan_code   : raw PS/2 byte
//   make_stb    : mapped key pressed (same cycle as the accepted byte)
//   rel_stb     : mapped key released (same cycle as the accepted byte)
//   key         : key index for make_stb / rel_stb
// -----------------------------------------------------------------------------
module kva_scan_parser
    import kva_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       make_stb,
    output logic       rel_stb,
    output logic [4:0] key
);

    parse_state_t state_reg;
    key_lookup_t  lookup;

    // Strobes are decoded from the current state and byte so that the voice
    // table can register the action on the same edge that accepts the byte;
    // registering them here would add a cycle to the visible latency.
    always_comb begin
        lookup   = key_idx(scan_code);
        make_stb = 1'b0;
        rel_stb  = 1'b0;
        key      = lookup.idx;
        if (scan_valid && !reset) begin
            case (state_reg)
                PS_IDLE:  make_stb = lookup.hit;
                PS_BREAK: rel_stb  = lookup.hit;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= PS_IDLE;
        end else if (scan_valid) begin
            case (state_reg)
                PS_IDLE: begin
                    if (scan_code == SC_BREAK)    state_reg <= PS_BREAK;
                    else if (scan_code == SC_EXT) state_reg <= PS_EXT;
                    else                          state_reg <= PS_IDLE;
                end
                PS_BREAK: begin
                    // Repeated F0 keeps waiting for the released key.
                    if (scan_code == SC_BREAK)    state_reg <= PS_BREAK;
                    else if (scan_code == SC_EXT) state_reg <= PS_EXT_BRK;
                    else                          state_reg <= PS_IDLE;
                end
                PS_EXT: begin
                    if (scan_code == SC_BREAK)    state_reg <= PS_EXT_BRK;
                    else                          state_reg <= PS_IDLE;
                end
                default: state_reg <= PS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keyboard_voice_alloc.sv
// -----------------------------------------------------------------------------
// keyboard_voice_alloc
// Parses a PS/2 scan-code stream, tracks held keys and allocates them to
// NUM_VOICES tone generators. When all voices are busy the oldest one is
// stolen. In mono mode only voice 0 is used.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   scan_valid  : one-cycle strobe qualifying scan_code
//   scan_code   : raw PS/2 byte
//   mono        : 0 = polyphonic allocation, 1 = voice 0 only
//   sound       : per-voice frequency word, voice v at [v*FREQ_W +: FREQ_W]
//   sound_off   : per-voice gate, 1 = sounding
//   voice_key   : per-voice key index, voice v at [v*5 +: 5]
//   key_down    : held-key bitmap
//   steal       : one-cycle pulse when a busy voice is reassigned
// -----------------------------------------------------------------------------
module keyboard_voice_alloc
    import kva_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int FREQ_W     = 16,
    parameter int AGE_W      = 4,
    parameter int NUM_KEYS   = KVA_NUM_KEYS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         scan_valid,
    input  logic [7:0]                   scan_code,
    input  logic                         mono,
    output logic [NUM_VOICES*FREQ_W-1:0] sound,
    output logic [NUM_VOICES-1:0]        sound_off,
    output logic [NUM_VOICES*5-1:0]      voice_key,
    output logic [NUM_KEYS-1:0]          key_down,
    output logic                         steal
);

    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic             make_stb;
    logic             rel_stb;
    logic [4:0]       key;

    logic [FREQ_W-1:0] sound_reg [NUM_VOICES];
    logic [FREQ_W-1:0] sound_next[NUM_VOICES];
    logic [4:0]        vkey_reg  [NUM_VOICES];
    logic [4:0]        vkey_next [NUM_VOICES];
    logic [AGE_W-1:0]  age_reg   [NUM_VOICES];
    logic [AGE_W-1:0]  age_next  [NUM_VOICES];
    logic [NUM_VOICES-1:0] busy_reg,  busy_next;
    logic [NUM_KEYS-1:0]   key_down_reg, key_down_next;
    logic              steal_reg, steal_next;
    logic              mono_reg;

    logic              mode_chg;
    logic              found_free;
    logic [VIDX_W-1:0] free_idx;
    logic [VIDX_W-1:0] old_idx;
    logic [AGE_W-1:0]  old_age;
    logic [VIDX_W-1:0] chosen;

    kva_scan_parser u_parser (
        .clk        (clk),
        .reset      (reset),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .make_stb   (make_stb),
        .rel_stb    (rel_stb),
        .key        (key)
    );

    // Any change of mono since the last edge flushes the voice table.
    assign mode_chg = (mono != mono_reg);

    always_comb begin
        // Start from the flushed table on a mode change so a byte arriving in
        // the same cycle is applied to the freshly freed voices.
        busy_next     = mode_chg ? '0 : busy_reg;
        key_down_next = mode_chg ? '0 : key_down_reg;
        steal_next    = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            sound_next[v] = sound_reg[v];
            vkey_next[v]  = vkey_reg[v];
            age_next[v]   = mode_chg ? '0 : age_reg[v];
        end

        // Lowest-index free voice.
        found_free = 1'b0;
        free_idx   = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!busy_next[v] && !found_free) begin
                found_free = 1'b1;
                free_idx   = VIDX_W'(v);
            end
        end

        // Oldest voice; strict compare keeps the lowest index on ties.
        old_idx = '0;
        old_age = age_next[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_next[v] > old_age) begin
                old_age = age_next[v];
                old_idx = VIDX_W'(v);
            end
        end

        chosen = '0;
        if (make_stb && !key_down_next[key]) begin
            if (mono) begin
                chosen = '0;
                if (busy_next[0]) key_down_next[vkey_next[0]] = 1'b0;
            end else if (found_free) begin
                chosen = free_idx;
            end else begin
                chosen     = old_idx;
                steal_next = 1'b1;
                key_down_next[vkey_next[old_idx]] = 1'b0;
            end
            key_down_next[key] = 1'b1;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (VIDX_W'(v) == chosen) begin
                    sound_next[v] = FREQ_W'(key_freq(key));
                    vkey_next[v]  = key;
                    age_next[v]   = '0;
                    busy_next[v]  = 1'b1;
                end else if (busy_next[v] && (age_next[v] != '1)) begin
                    age_next[v] = age_next[v] + 1'b1;
                end
            end
        end else if (rel_stb && key_down_next[key]) begin
            key_down_next[key] = 1'b0;
            // Only the gate drops; frequency and key stay for the decay path.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (busy_next[v] && (vkey_next[v] == key)) busy_next[v] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                sound_reg[v] <= FREQ_W'(1);
                vkey_reg[v]  <= '0;
                age_reg[v]   <= '0;
            end
            busy_reg     <= '0;
            key_down_reg <= '0;
            steal_reg    <= 1'b0;
            // Track the current mode so leaving reset does not look like a mode edge.
            mono_reg     <= mono;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                sound_reg[v] <= sound_next[v];
                vkey_reg[v]  <= vkey_next[v];
                age_reg[v]   <= age_next[v];
            end
            busy_reg     <= busy_next;
            key_down_reg <= key_down_next;
            steal_reg    <= steal_next;
            mono_reg     <= mono;
        end
    end

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice_out
        assign sound[gi*FREQ_W +: FREQ_W] = sound_reg[gi];
        assign voice_key[gi*5 +: 5]       = vkey_reg[gi];
    end

    // Gate follows occupancy directly so a free voice can never sound.
    assign sound_off = busy_reg;
    assign key_down  = key_down_reg;
    assign steal     = steal_reg;

endmodule
